fifo_rd_stream_adapter: RTL

- Downstream consumer of the synchronous FIFO read port: issues rd_en, absorbs the FIFO's 1-cycle read latency and presents words on a valid/ready stream.
- Holds a 2-entry skid buffer so the stream sustains 1 word/cycle under continuous m_ready.
- Provides flush, a delivered-word counter and a sticky FIFO-underflow error flag for the FIFO verification environment.

---
 rtl/fifo_rd_stream_adapter_if.sv | 33 +++
 rtl/fifo_rd_stream_adapter.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read-port and valid/ready stream bundle used by fifo_rd_stream_adapter.
// master = the adapter side, slave = the FIFO/sink environment side.
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH = 16
);
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_data_out,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_underflow,
        output fifo_data_out,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Reads a 1-cycle-latency synchronous FIFO and re-presents its words on a
// valid/ready stream through a 2-entry skid buffer, with flush and status.
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_rd_stream_adapter_if.master bus,
    input  logic                    flush,
    output logic [CNT_WIDTH-1:0]    delivered_cnt,
    output logic                    err_underflow
);
    logic [1:0]            count_q, count_d;
    logic                  in_flight_q, in_flight_d;
    logic                  discard_q, discard_d;
    logic [FIFO_WIDTH-1:0] entry0_q, entry0_d;
    logic [FIFO_WIDTH-1:0] entry1_q, entry1_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  pop_s;
    logic                  push_s;
    logic                  rd_en_s;
    logic [2:0]            credit_s;

    // Credit rule: never have more words buffered plus in transit than the buffer holds.
    always_comb begin
        pop_s    = (count_q != 2'd0) & bus.m_ready;
        push_s   = in_flight_q & ~discard_q;
        credit_s = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop_s};
        rd_en_s  = ~rst & ~flush & ~bus.fifo_empty & (credit_s < 3'd2);
    end

    // Next-state for buffer, flight tracking, counter and error flag.
    always_comb begin
        count_d     = count_q;
        entry0_d    = entry0_q;
        entry1_d    = entry1_q;
        cnt_d       = cnt_q;
        discard_d   = 1'b0;
        in_flight_d = rd_en_s;
        err_d       = err_q | (in_flight_q & bus.fifo_underflow);
        if (flush) begin
            // A pop presented in the flush cycle is dropped, not counted.
            count_d   = 2'd0;
            discard_d = in_flight_q;
        end else begin
            if (pop_s) begin
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            case ({push_s, pop_s})
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_d = bus.fifo_data_out;
                    end else begin
                        entry1_d = bus.fifo_data_out;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0_d = bus.fifo_data_out;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = bus.fifo_data_out;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
            entry0_q    <= {FIFO_WIDTH{1'b0}};
            entry1_q    <= {FIFO_WIDTH{1'b0}};
            cnt_q       <= {CNT_WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            entry0_q    <= entry0_d;
            entry1_q    <= entry1_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = (count_q != 2'd0);
    assign bus.m_data     = (count_q != 2'd0) ? entry0_q : {FIFO_WIDTH{1'b0}};
    assign delivered_cnt  = cnt_q;
    assign err_underflow  = err_q;

endmodule
